histogram_updater: RTL and testbench

- Upstream feeder for the histogram memory. It accepts a stream of raw samples, maps each sample to a bin and performs a saturating read-modify-write increment of that bin.
- At end of frame it drains the pipeline, then streams every bin count out to the plot/readout stage with a valid/ready handshake.
- It drives the memory's rd_add, wr, wr_add and wr_data ports, and consumes its rd_data and rdy.
- Memory contract: asynchronous read; a write becomes visible to reads on the cycle after the write edge.

---
 rtl/histogram_updater_pkg.sv | 29 ++
 rtl/histogram_updater_if.sv | 45 ++++
 rtl/histogram_updater_sat_inc.sv | 23 ++
 rtl/histogram_updater.sv | 141 ++++++++++++++
 tb/tb_histogram_updater.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/histogram_updater_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hist_pkg
// Brief    : Shared constants, state type and sample-to-bin mapping for the
//            histogram updater.
// Revision : 1.0 - initial release
// ============================================================================
package hist_pkg;

    localparam int SAMPLE_W = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int BINS     = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        DUMP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // The bin is the top ADDR_W bits of the sample.
    function automatic logic [ADDR_W-1:0] bin_of(input logic [SAMPLE_W-1:0] sample);
        return sample[SAMPLE_W-1 -: ADDR_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_updater_if.sv
`default_nettype none
// ============================================================================
// Module   : histogram_updater_if
// Brief    : Sample stream, histogram memory port and dump stream bundled
//            together. slave = updater view, master = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface histogram_updater_if;
    import hist_pkg::*;

    // sample stream
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_data;
    logic                in_last;
    // histogram memory
    logic                mem_rdy;
    logic [ADDR_W-1:0]   mem_rd_add;
    logic [DATA_W-1:0]   mem_rd_data;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_wr_add;
    logic [DATA_W-1:0]   mem_wr_data;
    // dump stream and status
    logic                out_valid;
    logic                out_ready;
    logic [ADDR_W-1:0]   out_bin;
    logic [DATA_W-1:0]   out_count;
    logic                out_last;
    logic                sat;
    logic                done;

    modport slave (
        input  in_valid, in_data, in_last, mem_rdy, mem_rd_data, out_ready,
        output in_ready, mem_rd_add, mem_wr, mem_wr_add, mem_wr_data,
               out_valid, out_bin, out_count, out_last, sat, done
    );

    modport master (
        output in_valid, in_data, in_last, mem_rdy, mem_rd_data, out_ready,
        input  in_ready, mem_rd_add, mem_wr, mem_wr_add, mem_wr_data,
               out_valid, out_bin, out_count, out_last, sat, done
    );

endinterface
`default_nettype wire

// File: rtl/histogram_updater_sat_inc.sv
`default_nettype none
// ============================================================================
// Module   : hist_sat_inc
// Brief    : Combinational saturating +1 on a bin count, with a flag raised
//            when the input is already at the maximum count.
// Revision : 1.0 - initial release
// ============================================================================
module hist_sat_inc
    import hist_pkg::*;
(
    input  wire logic [DATA_W-1:0] i_count,
    output logic      [DATA_W-1:0] o_count,
    output logic                   o_ovf
);

    // All-ones input means the bin is full: hold it and flag the overflow.
    always_comb begin
        o_ovf   = &i_count;
        o_count = o_ovf ? i_count : i_count + 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/histogram_updater.sv
`default_nettype none
// ============================================================================
// Module   : histogram_updater
// Brief    : Maps samples to bins and does a saturating read-modify-write
//            increment in the histogram memory; at end of frame drains the
//            pipeline and streams every bin count out.
//            Optional build macro HIST_UPDATER_CLEAR_ON_DUMP_EN: each dump
//            handshake also writes zero to the dumped bin.
// Revision : 1.0 - initial release
// ============================================================================
module histogram_updater
    import hist_pkg::*;
(
    input  wire logic          tb_clk,
    input  wire logic          rst,
    histogram_updater_if.slave bus
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_s1_valid;
    logic [ADDR_W-1:0]   r_s1_bin;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_sat;

    logic                w_in_hs;
    logic                w_stage2;
    logic                w_dump;
    logic                w_out_hs;
    logic                w_last;
    logic [DATA_W-1:0]   w_inc;
    logic                w_ovf;

    hist_sat_inc u_sat_inc (
        .i_count (bus.mem_rd_data),
        .o_count (w_inc),
        .o_ovf   (w_ovf)
    );

    // Handshake and stage qualifiers; stage 2 is suppressed while the memory clears.
    always_comb begin
        w_in_hs  = bus.in_valid && (r_state == ACCUM) && bus.mem_rdy;
        w_stage2 = r_s1_valid && bus.mem_rdy;
        w_dump   = (r_state == DUMP);
        w_out_hs = w_dump && bus.out_ready;
        w_last   = w_dump && (r_idx == ADDR_W'(BINS - 1));
    end

    // State register.
    always_ff @(posedge tb_clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; losing mem_rdy always returns to IDLE.
    always_comb begin
        w_next_state = r_state;
        if (!bus.mem_rdy) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next_state = ACCUM;
                ACCUM:   if (w_in_hs && bus.in_last) w_next_state = DRAIN;
                DRAIN:   w_next_state = DUMP;
                DUMP:    if (w_out_hs && w_last) w_next_state = DONE;
                DONE:    w_next_state = ACCUM;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Stage-1 capture, dump index and sticky saturation flag.
    always_ff @(posedge tb_clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_bin   <= '0;
            r_idx      <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_s1_valid <= w_in_hs;
            if (w_in_hs) begin
                r_s1_bin <= bin_of(bus.in_data);
            end

            if (!bus.mem_rdy || r_state == DRAIN) begin
                r_idx <= '0;
            end else if (w_out_hs) begin
                r_idx <= r_idx + 1'b1;
            end

            if (!bus.mem_rdy || r_state == DONE) begin
                r_sat <= 1'b0;
            end else if (w_stage2 && w_ovf) begin
                r_sat <= 1'b1;
            end
        end
    end

    // Memory port: dump reads by index, otherwise stage 2 reads/writes s1_bin.
    always_comb begin
        bus.mem_rd_add  = '0;
        bus.mem_wr      = 1'b0;
        bus.mem_wr_add  = '0;
        bus.mem_wr_data = '0;
        if (w_dump) begin
            bus.mem_rd_add = r_idx;
        end else if (r_s1_valid) begin
            bus.mem_rd_add = r_s1_bin;
        end
        if (w_stage2) begin
            bus.mem_wr      = 1'b1;
            bus.mem_wr_add  = r_s1_bin;
            bus.mem_wr_data = w_inc;
        end
`ifdef HIST_UPDATER_CLEAR_ON_DUMP_EN
        else if (w_out_hs) begin
            // out_count already carries the pre-clear value this cycle.
            bus.mem_wr      = 1'b1;
            bus.mem_wr_add  = r_idx;
            bus.mem_wr_data = '0;
        end
`else
`endif
    end

    // Stream and status outputs.
    always_comb begin
        bus.in_ready  = (r_state == ACCUM) && bus.mem_rdy;
        bus.out_valid = w_dump;
        bus.out_bin   = w_dump ? r_idx : '0;
        bus.out_count = w_dump ? bus.mem_rd_data : '0;
        bus.out_last  = w_last;
        bus.sat       = r_sat;
        bus.done      = (r_state == DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_histogram_updater.sv
`default_nettype none
// ============================================================================
// Module   : tb_histogram_updater
// Brief    : Self-checking bench for histogram_updater with a behavioural
//            histogram memory and a per-bin hit-count reference model.
//            Honours HIST_UPDATER_CLEAR_ON_DUMP_EN in its expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_histogram_updater;
    import hist_pkg::*;

    localparam int MAXC = 2 ** DATA_W - 1;

    logic tb_clk = 1'b0;
    logic rst    = 1'b1;
    logic clr    = 1'b1;

    always #5 tb_clk = ~tb_clk;

    histogram_updater_if bus ();

    histogram_updater dut (
        .tb_clk (tb_clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    // Histogram memory: async read, write on the edge, bulk clear while clr.
    logic [DATA_W-1:0] mem [BINS];
    assign bus.mem_rd_data = mem[bus.mem_rd_add];

    always @(posedge tb_clk) begin
        if (clr) begin
            for (int i = 0; i < BINS; i++) mem[i] <= '0;
        end else if (bus.mem_wr) begin
            mem[bus.mem_wr_add] <= bus.mem_wr_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int ref_cnt [BINS];
    bit sat_exp;
    logic [SAMPLE_W-1:0] frame_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_count(input int b);
        return (ref_cnt[b] > MAXC) ? MAXC : ref_cnt[b];
    endfunction

    task automatic do_reset();
        rst = 1'b1; clr = 1'b1; bus.mem_rdy = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (3) begin @(posedge tb_clk); #1; end
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last",  bus.out_last, 0);
        check("rst_mem_wr",    bus.mem_wr, 0);
        check("rst_sat",       bus.sat, 0);
        check("rst_done",      bus.done, 0);
        check("rst_addrs",     {bus.mem_rd_add, bus.mem_wr_add, bus.mem_wr_data}, 0);
        rst = 1'b0;
        repeat (2) begin @(posedge tb_clk); #1; end
        check("clearing_in_ready", bus.in_ready, 0);
        clr = 1'b0; bus.mem_rdy = 1'b1;
        @(posedge tb_clk); #1;
        check("accum_in_ready", bus.in_ready, 1);
        for (int i = 0; i < BINS; i++) ref_cnt[i] = 0;
        sat_exp = 1'b0;
    endtask

    task automatic push(input logic [SAMPLE_W-1:0] d, input bit last, input int gap);
        int t;
        int b;
        repeat (gap) begin @(posedge tb_clk); #1; end
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
        t = 0;
        while (!bus.in_ready && t < 50) begin @(posedge tb_clk); #1; t++; end
        if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
        @(posedge tb_clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        b = int'(d) / (2 ** (SAMPLE_W - ADDR_W));
        if (ref_cnt[b] >= MAXC) sat_exp = 1'b1;
        ref_cnt[b]++;
    endtask

    task automatic send_queue(input bit gaps);
        for (int i = 0; i < frame_q.size(); i++)
            push(frame_q[i], i == frame_q.size() - 1, gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    // mode 0: always ready, 1: alternate 1/0, 2: random ready.
    task automatic collect_dump(input int mode);
        int k;
        int cyc;
        bit held;
        logic [ADDR_W-1:0] h_bin;
        logic [DATA_W-1:0] h_cnt;
        logic              h_last;
        k = 0; cyc = 0; held = 1'b0; h_bin = '0; h_cnt = '0; h_last = 1'b0;
        while (k < BINS && cyc < 400) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = cyc[0];
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge tb_clk);
            if (bus.out_valid) begin
                if (held) begin
                    check("stall_bin",   bus.out_bin, h_bin);
                    check("stall_count", bus.out_count, h_cnt);
                    check("stall_last",  bus.out_last, h_last);
                end
                if (bus.out_ready) begin
                    check("dump_bin",   bus.out_bin, k);
                    check("dump_count", bus.out_count, exp_count(k));
                    check("dump_last",  bus.out_last, k == BINS - 1);
                    check("dump_sat",   bus.sat, sat_exp);
                    k++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; h_bin = bus.out_bin; h_cnt = bus.out_count; h_last = bus.out_last;
                end
            end
            @(posedge tb_clk); #1;
            cyc++;
        end
        check("dump_complete", k, BINS);
        bus.out_ready = 1'b0;
        @(negedge tb_clk);
        check("done_pulse",       bus.done, 1);
        check("done_out_valid",   bus.out_valid, 0);
        @(posedge tb_clk); #1;
        @(negedge tb_clk);
        check("done_single",      bus.done, 0);
        check("sat_after_done",   bus.sat, 0);
        check("in_ready_reentry", bus.in_ready, 1);
        @(posedge tb_clk); #1;
`ifdef HIST_UPDATER_CLEAR_ON_DUMP_EN
        for (int i = 0; i < BINS; i++) ref_cnt[i] = 0;
`endif
        sat_exp = 1'b0;
    endtask

    initial begin
        int t;
        logic [SAMPLE_W-1:0] r;
        bus.mem_rdy = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;
        do_reset();

        // Three bins hit once each.
        frame_q = '{8'h00, 8'h20, 8'hE0};
        send_queue(1'b0);
        collect_dump(0);

        // Back-to-back hits on one bin.
        frame_q = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        send_queue(1'b0);
        collect_dump(0);

        // Random frame with gaps, dump under alternating backpressure.
        frame_q.delete();
        for (int i = 0; i < 20; i++) frame_q.push_back(SAMPLE_W'($urandom));
        send_queue(1'b1);
        collect_dump(1);

        // Saturation: 260 hits on bin 3.
        frame_q.delete();
        for (int i = 0; i < 260; i++) begin
            r = SAMPLE_W'($urandom);
            r[SAMPLE_W-1 -: ADDR_W] = ADDR_W'(3);
            frame_q.push_back(r);
        end
        send_queue(1'b0);
        check("sat_during_frame_end", bus.sat, 1);
        collect_dump(2);

        // Two identical frames from a freshly cleared memory.
        do_reset();
        frame_q.delete();
        for (int i = 0; i < 12; i++) frame_q.push_back(SAMPLE_W'($urandom));
        send_queue(1'b1);
        collect_dump(2);
        send_queue(1'b1);
        collect_dump(0);

        // Reset in the middle of a dump.
        frame_q = '{8'h10, 8'hA0};
        send_queue(1'b0);
        t = 0;
        while (!bus.out_valid && t < 20) begin @(posedge tb_clk); #1; t++; end
        check("middump_started", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        repeat (2) begin @(posedge tb_clk); #1; end
        rst = 1'b1;
        @(posedge tb_clk); #1;
        check("middump_out_valid", bus.out_valid, 0);
        check("middump_in_ready",  bus.in_ready, 0);
        check("middump_mem_wr",    bus.mem_wr, 0);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
